// File: rtl/iir_frame_sched.sv
// Frame sequencer for the cascaded-SOS IIR datapath: sample addressing, section enable, settle gating, flush and done.
// Optional watchdog (sticky wdog_err, abandons a stalled frame) is built when IIR_SCHED_WDOG_EN is defined.
module iir_frame_sched #(
   parameter int N_SAMPLES = 2048,
   parameter int ADDR_W    = 11,
   parameter int N_SECT    = 7,
   parameter int SETTLE    = 16,
   parameter int FLUSH_CYC = 64,
   parameter int WDOG_CYC  = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              din_valid,
   input  logic              sect_valid_last,
   output logic [ADDR_W-1:0] addr,
   output logic              pipeline_en,
   output logic              stable_out,
   output logic              data_out_valid,
   output logic [ADDR_W:0]   out_cnt,
   output logic              busy,
   output logic              filter_done
`ifdef IIR_SCHED_WDOG_EN
   ,
   output logic              wdog_err
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

   localparam int FL_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
   localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(N_SAMPLES - 1);
   localparam logic [ADDR_W:0]   CNT_MAX    = (ADDR_W + 1)'(N_SAMPLES);
   localparam logic [ADDR_W:0]   CNT_SETTLE = (ADDR_W + 1)'(SETTLE);
   localparam logic [FL_W-1:0]   FLUSH_LAST = FL_W'(FLUSH_CYC - 1);

   if (N_SECT < 1 || WDOG_CYC < 1 || (1 << ADDR_W) < N_SAMPLES) begin : g_bad_cfg
      $error("iir_frame_sched: inconsistent parameters");
   end

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   out_cnt_q, out_cnt_d;
   logic              stable_q, stable_d;
   logic [FL_W-1:0]   flush_cnt_q, flush_cnt_d;
   logic              active;
   logic              accept_start;
   logic              last_in;
   logic              wdog_trip;

   assign active       = (state_q == S_RUN) || (state_q == S_FLUSH);
   assign accept_start = (state_q == S_IDLE) && start && !abort;
   assign last_in      = (state_q == S_RUN) && din_valid && (addr_q == ADDR_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         out_cnt_q   <= '0;
         stable_q    <= 1'b0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         out_cnt_q   <= out_cnt_d;
         stable_q    <= stable_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (accept_start) state_d = S_RUN;
         S_RUN: begin
            if (abort || wdog_trip) state_d = S_IDLE;
            else if (last_in)       state_d = S_FLUSH;
         end
         S_FLUSH: begin
            if (abort || wdog_trip) state_d = S_IDLE;
            else if (out_cnt_q == CNT_MAX || flush_cnt_q == FLUSH_LAST) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Counters freeze on abort/watchdog so the aborted frame's progress stays visible.
   always_comb begin
      addr_d      = addr_q;
      out_cnt_d   = out_cnt_q;
      stable_d    = stable_q;
      flush_cnt_d = flush_cnt_q;
      if (state_q == S_IDLE) begin
         stable_d = 1'b0;
         if (accept_start) begin
            addr_d    = '0;
            out_cnt_d = '0;
         end
      end else if (abort || wdog_trip || state_q == S_DONE) begin
         stable_d = 1'b0;
      end else begin
         if (state_q == S_RUN && din_valid && addr_q != ADDR_LAST) addr_d = addr_q + 1'b1;
         if (sect_valid_last && out_cnt_q != CNT_MAX) begin
            out_cnt_d = out_cnt_q + 1'b1;
            if (out_cnt_d == CNT_SETTLE) stable_d = 1'b1;
         end
         flush_cnt_d = (state_q == S_FLUSH) ? flush_cnt_q + 1'b1 : '0;
      end
   end

   always_comb begin
      pipeline_en    = active;
      busy           = (state_q != S_IDLE);
      filter_done    = (state_q == S_DONE);
      data_out_valid = sect_valid_last && stable_q && active;
   end

   assign addr       = addr_q;
   assign out_cnt    = out_cnt_q;
   assign stable_out = stable_q;

`ifdef IIR_SCHED_WDOG_EN
   localparam int WD_W = $clog2(WDOG_CYC + 1);
   localparam logic [WD_W-1:0] WDOG_LAST = WD_W'(WDOG_CYC - 1);

   logic [WD_W-1:0] wdog_cnt_q, wdog_cnt_d;
   logic            wdog_err_q, wdog_err_d;

   // Trip on the cycle the idle-output count would reach WDOG_CYC.
   assign wdog_trip = active && !sect_valid_last && (wdog_cnt_q == WDOG_LAST);

   always_comb begin
      wdog_cnt_d = (!active || sect_valid_last) ? '0 : wdog_cnt_q + 1'b1;
      wdog_err_d = wdog_err_q;
      if (wdog_trip)         wdog_err_d = 1'b1;
      else if (accept_start) wdog_err_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog_cnt_q <= '0;
         wdog_err_q <= 1'b0;
      end else begin
         wdog_cnt_q <= wdog_cnt_d;
         wdog_err_q <= wdog_err_d;
      end
   end

   assign wdog_err = wdog_err_q;
`else
   assign wdog_trip = 1'b0;
`endif

endmodule

// File: tb/tb_iir_frame_sched.sv
// Bench for iir_frame_sched: randomised frames driven through a fixed-latency pipeline model,
// expected addresses/outputs/done results queued at stimulus time and checked by an independent monitor.
module tb_iir_frame_sched;
   localparam int N_SAMPLES    = 2048;
   localparam int ADDR_W       = 11;
   localparam int N_SECT       = 7;
   localparam int SETTLE       = 16;
   localparam int FLUSH_CYC    = 64;
   localparam int WDOG_CYC     = 256;
   localparam int LAT          = 3 * N_SECT;
   localparam int FRAME_BUDGET = 4000;

   logic              clk, rst_n, start, abort, din_valid, sect_valid_last;
   logic [ADDR_W-1:0] addr;
   logic              pipeline_en, stable_out, data_out_valid, busy, filter_done;
   logic [ADDR_W:0]   out_cnt;
`ifdef IIR_SCHED_WDOG_EN
   logic              wdog_err;
`endif

   iir_frame_sched #(
      .N_SAMPLES(N_SAMPLES), .ADDR_W(ADDR_W), .N_SECT(N_SECT),
      .SETTLE(SETTLE), .FLUSH_CYC(FLUSH_CYC), .WDOG_CYC(WDOG_CYC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .din_valid(din_valid), .sect_valid_last(sect_valid_last),
      .addr(addr), .pipeline_en(pipeline_en), .stable_out(stable_out),
      .data_out_valid(data_out_valid), .out_cnt(out_cnt), .busy(busy),
      .filter_done(filter_done)
`ifdef IIR_SCHED_WDOG_EN
      , .wdog_err(wdog_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int dov_seen = 0;
   int done_seen = 0;
   int addr_exp[$];
   int ocnt_exp[$];
   int dov_exp[$];
   int done_addr_exp[$];
   int done_cnt_exp[$];
   int exp_addr_hold = 0;
   int exp_cnt_hold  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_evt(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: event not expected by the model (t=%0t)", name, $time);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (din_valid && pipeline_en) begin
            if (addr_exp.size() == 0) fail_evt("addr_accept");
            else chk("addr", addr, addr_exp.pop_front());
         end
         if (sect_valid_last && pipeline_en) begin
            if (ocnt_exp.size() == 0) fail_evt("sect_output");
            else begin
               chk("out_cnt", out_cnt, ocnt_exp.pop_front());
               chk("data_out_valid", data_out_valid, dov_exp.pop_front());
            end
         end
         if (data_out_valid) dov_seen++;
         if (filter_done) begin
            done_seen++;
            if (done_addr_exp.size() == 0) fail_evt("filter_done");
            else begin
               chk("done_addr", addr, done_addr_exp.pop_front());
               chk("done_out_cnt", out_cnt, done_cnt_exp.pop_front());
            end
         end
      end
   end

   // gap_mode: 0 continuous, 1 gap every 4th cycle, 2 random gaps.
   task automatic run_frame(input int gap_mode, input int out_limit, input int abort_at,
                            input int mid_start_at);
      int sent, issued, cyc, last_in, last_out, done_cyc, exp_done, dov0, done0, n_out;
      int sched[$];
      bit dv;
      sent = 0; issued = 0; cyc = 0; last_in = -1; last_out = -1; done_cyc = -1;
      dov0 = dov_seen; done0 = done_seen;
      n_out = (out_limit < N_SAMPLES) ? out_limit : N_SAMPLES;
      if (abort_at < 0) begin
         done_addr_exp.push_back(N_SAMPLES - 1);
         done_cnt_exp.push_back(n_out);
      end
      @(posedge clk); #1;
      start = 1'b1;
      while (cyc < FRAME_BUDGET) begin
         @(posedge clk); #1;
         cyc++;
         start = 1'b0; din_valid = 1'b0; sect_valid_last = 1'b0;
         if (cyc == 1) chk("run_entry_busy", busy, 1);
         if (filter_done) begin
            done_cyc = cyc;
            break;
         end
         if (abort_at >= 0 && sent == abort_at) begin
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            chk("abort_busy", busy, 0);
            chk("abort_pipeline_en", pipeline_en, 0);
            chk("abort_stable", stable_out, 0);
            chk("abort_addr_hold", addr, abort_at);
            chk("abort_cnt_hold", out_cnt, issued);
            repeat (80) @(posedge clk);
            #1;
            chk("abort_no_done", done_seen - done0, 0);
            exp_addr_hold = abort_at;
            exp_cnt_hold  = issued;
            return;
         end
         start = (mid_start_at >= 0 && sent == mid_start_at);
         case (gap_mode)
            0:       dv = 1'b1;
            1:       dv = (cyc % 4) != 0;
            default: dv = $urandom_range(0, 3) != 0;
         endcase
         dv = dv && (sent < N_SAMPLES);
         din_valid = dv;
         if (dv) begin
            addr_exp.push_back(sent);
            sched.push_back(cyc + LAT);
            sent++;
            if (sent == N_SAMPLES) last_in = cyc;
         end
         if (sched.size() > 0 && sched[0] == cyc) begin
            void'(sched.pop_front());
            if (issued < out_limit) begin
               sect_valid_last = 1'b1;
               ocnt_exp.push_back(issued < N_SAMPLES ? issued : N_SAMPLES);
               dov_exp.push_back(issued >= SETTLE);
               issued++;
               last_out = cyc;
            end
         end
      end
      din_valid = 1'b0; sect_valid_last = 1'b0; start = 1'b0;
      if (done_cyc < 0) begin
         fail_evt("done_timeout");
         return;
      end
      exp_done = last_in + FLUSH_CYC + 1;
      if (n_out == N_SAMPLES && last_out + 2 < exp_done) exp_done = last_out + 2;
      chk("done_latency", done_cyc, exp_done);
      @(posedge clk); #1;
      chk("post_busy", busy, 0);
      chk("post_done_single", filter_done, 0);
      chk("post_stable", stable_out, 0);
      chk("post_addr", addr, N_SAMPLES - 1);
      chk("post_out_cnt", out_cnt, n_out);
      chk("dov_count", dov_seen - dov0, (n_out > SETTLE) ? n_out - SETTLE : 0);
      chk("done_count", done_seen - done0, 1);
      exp_addr_hold = N_SAMPLES - 1;
      exp_cnt_hold  = n_out;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; din_valid = 1'b0; sect_valid_last = 1'b0;
      #12;
      chk("rst_addr", addr, 0);
      chk("rst_out_cnt", out_cnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pipeline_en", pipeline_en, 0);
      chk("rst_stable", stable_out, 0);
      chk("rst_done", filter_done, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      run_frame(0, N_SAMPLES, -1, -1);
      run_frame(1, N_SAMPLES, -1, -1);
      run_frame(0, N_SAMPLES - 8, -1, -1);
      run_frame(0, N_SAMPLES, 1000, -1);
      run_frame(0, N_SAMPLES, -1, 500);

      // start and abort together in IDLE: abort wins
      @(posedge clk); #1;
      start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      chk("idle_abort_busy", busy, 0);
      chk("idle_abort_pen", pipeline_en, 0);
      chk("idle_abort_addr", addr, exp_addr_hold);
      chk("idle_abort_cnt", out_cnt, exp_cnt_hold);

      run_frame(2, N_SAMPLES, -1, -1);

`ifdef IIR_SCHED_WDOG_EN
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (WDOG_CYC - 1) @(posedge clk);
      #1;
      chk("wdog_still_run", busy, 1);
      chk("wdog_not_yet", wdog_err, 0);
      @(posedge clk); #1;
      chk("wdog_idle", busy, 0);
      chk("wdog_err_set", wdog_err, 1);
      chk("wdog_no_done", filter_done, 0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("wdog_err_clear", wdog_err, 0);
      chk("wdog_restart_addr", addr, 0);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
`endif

      // asynchronous reset in the middle of a frame
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 40; i++) begin
         din_valid = 1'b1;
         addr_exp.push_back(i);
         @(posedge clk); #1;
      end
      din_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_addr", addr, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_pen", pipeline_en, 0);
      addr_exp.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("midrst_stay_idle", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/iir_frame_sched.md
Name: iir_frame_sched

Overview:
Frame-level sequencer for the cascaded-SOS IIR datapath in opti_top. On a start pulse it sequences one frame of samples: it generates the sample address, enables the section pipeline, counts samples out of the last section, and gates output valid until the filter has settled. It flushes the pipeline at the end of the frame and signals completion with a single-cycle filter_done.

Parameters:
N_SAMPLES, 2048, samples per frame
ADDR_W, 11, address width; must satisfy 2^ADDR_W >= N_SAMPLES
N_SECT, 7, number of cascaded SOS sections
SETTLE, 16, number of initial last-section outputs suppressed before stable_out
FLUSH_CYC, 64, maximum pipeline-enable cycles after the last input
WDOG_CYC, 256, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  system clock; all logic on its rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse that begins a frame; ignored unless in IDLE
abort  in  1  synchronous abort; returns to IDLE on the next edge
din_valid  in  1  an input sample is presented this cycle
sect_valid_last  in  1  valid from the last SOS section (sos_valid[N_SECT-1])
addr  out  ADDR_W  index of the sample being accepted
pipeline_en  out  1  clock-enable for all SOS sections
stable_out  out  1  high once SETTLE outputs have been discarded
data_out_valid  out  1  sect_valid_last AND stable_out AND pipeline_en
out_cnt  out  ADDR_W+1  count of outputs produced in this frame, including discarded ones
busy  out  1  state is not IDLE
filter_done  out  1  one-cycle completion pulse
wdog_err  out  1  sticky watchdog error; present only with the optional feature

Behaviour:
- Reset: state is IDLE; every output and internal counter is 0.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - pipeline_en = 0.
  - On start: go to RUN, addr = 0, out_cnt = 0, stable_out = 0.
- RUN:
  - pipeline_en = 1.
  - Each cycle with din_valid, addr increments by 1.
  - When din_valid is high and addr == N_SAMPLES-1: addr holds, go to FLUSH, clear the flush counter.
  - din_valid low: addr holds. No gaps are filled.
- Output counting (RUN and FLUSH):
  - Each cycle with sect_valid_last: out_cnt increments, saturating at N_SAMPLES.
  - stable_out is registered and goes high on the edge where out_cnt becomes SETTLE. It stays high until the frame returns to IDLE.
  - data_out_valid is combinational from the registered terms listed in Ports.
- FLUSH:
  - pipeline_en = 1; the flush counter increments every cycle.
  - Go to DONE when out_cnt == N_SAMPLES or the flush counter == FLUSH_CYC-1, whichever comes first.
  - din_valid is ignored in FLUSH.
- DONE:
  - pipeline_en = 0; filter_done = 1 for exactly this one cycle.
  - Next cycle: IDLE. stable_out clears; addr and out_cnt hold their final values until the next start.
- start during RUN, FLUSH or DONE: ignored, no restart.
- abort (any state other than IDLE): go to IDLE on the next edge. pipeline_en, stable_out and busy drop. No filter_done pulse. addr and out_cnt hold.
- abort and start in the same cycle in IDLE: abort wins; stay in IDLE.
- rst_n low at any time, including mid-frame: immediate return to reset values.
- Nominal frame latency: start edge, then N_SAMPLES input cycles, then pipeline drain of about 3·N_SECT cycles, then the filter_done pulse.

Optional Feature:
IIR_SCHED_WDOG_EN
- Defined:
  - A watchdog counter clears on every sect_valid_last and otherwise counts in RUN and FLUSH.
  - On reaching WDOG_CYC: set wdog_err (sticky), go to IDLE, no filter_done.
  - wdog_err clears only on reset or on the next accepted start.
- Undefined:
  - wdog_err port is absent; no counter is built.
  - A stalled pipeline leaves the block in RUN, or in FLUSH until the flush limit.

Test Plan:
- Nominal frame: reset, start, 2048 continuous din_valid, model pipeline latency 21 -> addr runs 0..2047, stable_out rises on the 16th output, data_out_valid count = 2032, filter_done pulses exactly once, busy falls the cycle after.
- Gapped input: din_valid low every 4th cycle -> addr holds during gaps, final addr = 2047, out_cnt = 2048 at DONE.
- Flush limit: last section stops asserting valid after 2040 outputs -> DONE after exactly 64 FLUSH cycles, out_cnt = 2040, filter_done pulses once.
- Abort at addr = 1000 -> IDLE next cycle, pipeline_en = 0, no filter_done; a following start restarts at addr = 0 with out_cnt = 0.
- start pulsed again mid-RUN, and abort with start in IDLE -> no restart, addr sequence unbroken, state stays IDLE in the second case.
- IIR_SCHED_WDOG_EN, WDOG_CYC = 256: sect_valid_last held low for 256 cycles in RUN -> wdog_err = 1, state IDLE, no filter_done; next start clears wdog_err.
